// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a WIDTH-bit binary code through an external
// binary-to-Gray converter. Each code is held for DWELL cycles, then the
// converter output is sampled, checked and presented with a valid strobe.
// Counting can run up or down, as a single pass or continuously.
module gray_seq_ctrl #(
    parameter int WIDTH = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             dir,
    input  logic             cont,
    output logic [WIDTH-1:0] bin_out,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Parameter sanity checks at elaboration time.
    generate
        if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
            $error("gray_seq_ctrl: DWELL must be in 1..255");
        end
        if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
            $error("gray_seq_ctrl: WIDTH must be in 2..16");
        end
    endgenerate

    localparam int             CW        = 8;
    localparam logic [CW-1:0]  DWELL_M1  = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             dir_q, dir_d;
    logic             cont_q, cont_d;

    // Expected converter output for the code currently driven.
    logic [WIDTH-1:0] gray_exp;
    // Final code of a single pass for the latched direction.
    logic [WIDTH-1:0] last_code;

    assign gray_exp  = bin_q ^ (bin_q >> 1);
    assign last_code = dir_q ? ALL_ZERO : ALL_ONES;

    // State and output registers; async reset returns everything to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dir_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dir_q   <= dir_d;
            cont_q  <= cont_d;
        end
    end

    // Next-state logic: strobes default low, everything else holds.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        gray_d  = gray_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        dir_d   = dir_q;
        cont_d  = cont_q;

        unique case (state_q)
            S_IDLE: begin
                // stop has priority over start
                if (start && !stop) begin
                    dir_d   = dir;
                    cont_d  = cont;
                    bin_d   = dir ? ALL_ONES : ALL_ZERO;
                    cnt_d   = DWELL_M1;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end
            end

            // RUN and PAUSE share one decision tree: a PAUSE cycle with
            // pause low resumes stepping on that same edge, so a pause held
            // for N cycles delays the sequence by exactly N cycles.
            S_RUN, S_PAUSE: begin
                if (stop) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_RUN;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        gray_d  = gray_in;
                        valid_d = 1'b1;
                        if (gray_in != gray_exp) begin
                            err_d = 1'b1;
                        end
                        if (!cont_q && (bin_q == last_code)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            bin_d = dir_q ? (bin_q - 1'b1) : (bin_q + 1'b1);
                            cnt_d = DWELL_M1;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
